// File: rtl/tone_wave_gen.sv
// Note generator behind the tone decoder: latched pitch, sustain, then linear decay.
// Optional TONE_TRIANGLE_EN selects a triangle sample instead of the square sample.
module tone_wave_gen #(
  parameter logic [7:0]  AMP_MAX         = 8'd200,
  parameter logic [7:0]  SUSTAIN_PERIODS = 8'd8,
  parameter logic [15:0] DECAY_TICKS     = 16'd64
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [9:0]  preScaleValue,
  input  logic        enabler,
  output logic [15:0] sample_out,
  output logic        sample_strobe,
  output logic        square_out,
  output logic        busy
);

  localparam int unsigned PS_W  = 10;
  localparam int unsigned PH_W  = 8;
  localparam int unsigned AMP_W = 8;
  localparam int unsigned SMP_W = 16;
  localparam int unsigned DEC_W = 16;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    PLAY    = 2'd1,
    RELEASE = 2'd2
  } state_e;

  state_e             state_q, state_d;
  logic [PS_W-1:0]    ps_lat_q, ps_lat_d;
  logic [PS_W-1:0]    ps_cnt_q, ps_cnt_d;
  logic [PH_W-1:0]    phase_q, phase_d;
  logic [AMP_W-1:0]   amp_q, amp_d;
  logic [AMP_W-1:0]   sus_cnt_q, sus_cnt_d;
  logic [DEC_W-1:0]   dec_cnt_q, dec_cnt_d;
  logic [SMP_W-1:0]   sample_q, sample_d;
  logic               strobe_q;
  logic               square_q;
  logic               busy_q;
  logic               busy_d;
  logic               tick;
  logic               wrap;
  logic               ps_ok;
  logic               trigger;

  // Next-state: prescaler/phase advance, then per-state control
  always_comb begin
    state_d   = state_q;
    ps_lat_d  = ps_lat_q;
    ps_cnt_d  = ps_cnt_q;
    phase_d   = phase_q;
    amp_d     = amp_q;
    sus_cnt_d = sus_cnt_q;
    dec_cnt_d = dec_cnt_q;
    tick      = 1'b0;
    wrap      = 1'b0;
    ps_ok     = (preScaleValue != '0);
    trigger   = enabler && ps_ok;

    if (state_q != IDLE) begin
      tick = (ps_cnt_q == ps_lat_q - PS_W'(1));
      if (tick) begin
        ps_cnt_d = '0;
        phase_d  = phase_q + PH_W'(1);
        if (phase_q == '1) begin
          wrap = 1'b1;
          // New pitch only takes effect on a period boundary
          if (ps_ok) ps_lat_d = preScaleValue;
        end
      end else begin
        ps_cnt_d = ps_cnt_q + PS_W'(1);
      end
    end

    case (state_q)
      IDLE: begin
        if (trigger) begin
          state_d   = PLAY;
          ps_lat_d  = preScaleValue;
          ps_cnt_d  = '0;
          phase_d   = '0;
          amp_d     = AMP_MAX;
          sus_cnt_d = SUSTAIN_PERIODS;
        end
      end
      PLAY: begin
        if (enabler) begin
          sus_cnt_d = SUSTAIN_PERIODS;
        end else if (wrap) begin
          if (sus_cnt_q <= AMP_W'(1)) begin
            state_d   = RELEASE;
            dec_cnt_d = '0;
          end else begin
            sus_cnt_d = sus_cnt_q - AMP_W'(1);
          end
        end
      end
      RELEASE: begin
        if (trigger) begin
          // Phase and prescaler keep running so the waveform has no click
          state_d   = PLAY;
          amp_d     = AMP_MAX;
          sus_cnt_d = SUSTAIN_PERIODS;
        end else if (tick) begin
          if (dec_cnt_q == DECAY_TICKS - DEC_W'(1)) begin
            dec_cnt_d = '0;
            amp_d     = amp_q - AMP_W'(1);
            if (amp_q == AMP_W'(1)) begin
              state_d  = IDLE;
              phase_d  = '0;
              ps_cnt_d = '0;
            end
          end else begin
            dec_cnt_d = dec_cnt_q + DEC_W'(1);
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

`ifdef TONE_TRIANGLE_EN
  logic [6:0]         tri_t;
  logic signed [9:0]  tri_c;
  logic signed [18:0] tri_prod;
`else
  logic [SMP_W-1:0]   mag;
`endif

  // Sample for the upcoming phase/amp so it lines up with the strobe
  always_comb begin
    busy_d   = (state_d != IDLE);
    sample_d = '0;
`ifdef TONE_TRIANGLE_EN
    tri_t    = phase_d[7] ? ~phase_d[6:0] : phase_d[6:0];
    tri_c    = $signed({2'b00, tri_t, 1'b0}) - 10'sd128;
    tri_prod = tri_c * $signed({1'b0, amp_d});
    if (busy_d) sample_d = SMP_W'(tri_prod);
`else
    mag      = {1'b0, amp_d, 7'b0};
    if (busy_d) sample_d = phase_d[7] ? SMP_W'(-mag) : mag;
`endif
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      ps_lat_q  <= '0;
      ps_cnt_q  <= '0;
      phase_q   <= '0;
      amp_q     <= '0;
      sus_cnt_q <= '0;
      dec_cnt_q <= '0;
      sample_q  <= '0;
      strobe_q  <= 1'b0;
      square_q  <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      ps_lat_q  <= ps_lat_d;
      ps_cnt_q  <= ps_cnt_d;
      phase_q   <= phase_d;
      amp_q     <= amp_d;
      sus_cnt_q <= sus_cnt_d;
      dec_cnt_q <= dec_cnt_d;
      sample_q  <= sample_d;
      strobe_q  <= tick;
      square_q  <= busy_d & phase_d[7];
      busy_q    <= busy_d;
    end
  end

  assign sample_out    = sample_q;
  assign sample_strobe = strobe_q;
  assign square_out    = square_q;
  assign busy          = busy_q;

endmodule

// File: tb/tb_tone_wave_gen.sv
// Directed bench for tone_wave_gen (AMP_MAX=200, SUSTAIN_PERIODS=2, DECAY_TICKS=4).
// Expected samples follow TONE_TRIANGLE_EN when the bench is built with it.
module tb_tone_wave_gen;

  logic        clk;
  logic        reset;
  logic [9:0]  preScaleValue;
  logic        enabler;
  logic [15:0] sample_out;
  logic        sample_strobe;
  logic        square_out;
  logic        busy;

  int pass_cnt = 0;
  int fail_cnt = 0;
  int total    = 0;
  int c        = 0;
  int n        = 0;
  int strobes  = 0;

  tone_wave_gen #(
    .AMP_MAX        (8'd200),
    .SUSTAIN_PERIODS(8'd2),
    .DECAY_TICKS    (16'd4)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .preScaleValue(preScaleValue),
    .enabler      (enabler),
    .sample_out   (sample_out),
    .sample_strobe(sample_strobe),
    .square_out   (square_out),
    .busy         (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic int exp_sample(input int ph, input int a);
`ifdef TONE_TRIANGLE_EN
    int t;
    t = (ph < 128) ? ph : 255 - ph;
    return (2 * t - 128) * a;
`else
    return (ph < 128) ? a * 128 : -a * 128;
`endif
  endfunction

  task automatic check(input string tag, input int obs, input int exp);
    total++;
    assert (obs === exp) pass_cnt++;
    else begin
      fail_cnt++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic adv(input int k);
    repeat (k) @(posedge clk);
    #1;
    c += k;
  endtask

  // Cycles until the next strobe, bounded; -1 on timeout
  task automatic next_strobe(output int cnt);
    cnt = 0;
    do begin
      adv(1);
      cnt++;
    end while (!sample_strobe && cnt < 5000);
    if (!sample_strobe) cnt = -1;
  endtask

  initial begin
    reset = 1'b1; enabler = 1'b0; preScaleValue = '0;
    adv(2);
    reset = 1'b0;

    // Reset mid-note, enabler held high during reset
    preScaleValue = 10'd3; enabler = 1'b1;
    adv(1);
    enabler = 1'b0;
    adv(50);
    check("pre_reset_busy", int'(busy), 1);
    reset = 1'b1; enabler = 1'b1;
    adv(1);
    check("rst_busy", int'(busy), 0);
    check("rst_sample", int'($signed(sample_out)), 0);
    check("rst_square", int'(square_out), 0);
    check("rst_strobe", int'(sample_strobe), 0);
    adv(2);
    check("rst3_busy", int'(busy), 0);
    reset = 1'b0; enabler = 1'b0;
    adv(1);
    check("post_rst_busy", int'(busy), 0);

    // Zero prescale is ignored
    preScaleValue = '0; enabler = 1'b1;
    strobes = 0;
    for (int i = 0; i < 20; i++) begin
      adv(1);
      strobes += int'(sample_strobe) + int'(busy);
    end
    check("zero_ps_activity", strobes, 0);
    check("zero_ps_sample", int'($signed(sample_out)), 0);
    enabler = 1'b0;
    adv(1);

    // Pitch 0x118: strobe spacing 280, half period 35840
    preScaleValue = 10'h118; enabler = 1'b1;
    adv(1); c = 0;
    check("pitch_busy", int'(busy), 1);
    check("pitch_s0", int'($signed(sample_out)), exp_sample(0, 200));
    check("pitch_sq0", int'(square_out), 0);
    adv(1);
    enabler = 1'b0;
    while (!sample_strobe && c < 1000) adv(1);
    check("pitch_first_strobe", c, 280);
    adv(17920 - c);
    check("pitch_s64", int'($signed(sample_out)), exp_sample(64, 200));
    adv(35839 - c);
    check("pitch_sq127", int'(square_out), 0);
    adv(1);
    check("pitch_sq128", int'(square_out), 1);
    check("pitch_s128", int'($signed(sample_out)), exp_sample(128, 200));
    reset = 1'b1;
    adv(1);
    reset = 1'b0;

    // Pitch change at phase 40 applies only after the wrap
    preScaleValue = 10'd15; enabler = 1'b1;
    adv(1);
    for (int i = 0; i < 40; i++) next_strobe(n);
    check("glitch_s40", int'($signed(sample_out)), exp_sample(40, 200));
    preScaleValue = 10'd10;
    next_strobe(n);
    check("glitch_gap_pre", n, 15);
    for (int i = 0; i < 214; i++) next_strobe(n);
    next_strobe(n);
    check("glitch_gap_wrap", n, 15);
    check("glitch_sq_wrap", int'(square_out), 0);
    next_strobe(n);
    check("glitch_gap_post", n, 10);
    enabler = 1'b0;
    reset = 1'b1;
    adv(1);
    reset = 1'b0;

    // Sustain 2 periods, then decay 1 step per 4 ticks
    preScaleValue = 10'd15; enabler = 1'b1;
    adv(1); c = 0;
    enabler = 1'b0;
    adv(7679);
    check("sus_end_busy", int'(busy), 1);
    check("sus_s255", int'($signed(sample_out)), exp_sample(255, 200));
    adv(1);
    check("rel_s0", int'($signed(sample_out)), exp_sample(0, 200));
    adv(59);
    check("rel_pre_dec", int'($signed(sample_out)), exp_sample(3, 200));
    adv(1);
    check("rel_first_dec", int'($signed(sample_out)), exp_sample(4, 199));
    adv(19679 - c);
    check("rel_last_busy", int'(busy), 1);
    check("rel_last_s", int'($signed(sample_out)), exp_sample(31, 1));
    adv(1);
    check("rel_done_busy", int'(busy), 0);
    check("rel_done_s", int'($signed(sample_out)), 0);
    check("rel_done_sq", int'(square_out), 0);
    strobes = 0;
    for (int i = 0; i < 10; i++) begin
      adv(1);
      strobes += int'(sample_strobe);
    end
    check("idle_no_strobe", strobes, 0);

    // Retrigger in RELEASE at amp 37, phase continues
    preScaleValue = 10'd1; enabler = 1'b1;
    adv(1); c = 0;
    enabler = 1'b0;
    adv(1164);
    check("retrig_amp37", int'($signed(sample_out)), exp_sample(140, 37));
    enabler = 1'b1;
    adv(1);
    enabler = 1'b0;
    check("retrig_s", int'($signed(sample_out)), exp_sample(141, 200));
    check("retrig_busy", int'(busy), 1);
    check("retrig_sq", int'(square_out), 1);
    adv(1279 - c);
    check("retrig_sq255", int'(square_out), 1);
    adv(1);
    check("retrig_sq_wrap", int'(square_out), 0);
    check("retrig_s_wrap", int'($signed(sample_out)), exp_sample(0, 200));

    $display("%0d/%0d checks passed", pass_cnt, total);
    $finish;
  end

endmodule
